hazard3_pmp_lsu_gate: RTL and testbench

Load/store access gate between the core's load/store request path and the data bus master. It registers each request, presents the registered address to the PMP data-side query, and samples the kill result. It issues the bus transfer only if the request is permitted; otherwise it returns an access-fault response without touching the bus. It also captures the first faulting address for trap reporting.

---
 rtl/hazard3_pmp_lsu_gate.sv | 163 ++++++++++++++++
 tb/tb_hazard3_pmp_lsu_gate.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_pmp_lsu_gate.sv
// Load/store access gate: registers one request, runs the PMP data-side check,
// then either issues the bus transfer or returns an alignment/PMP fault.
`timescale 1ns/1ps
module hazard3_pmp_lsu_gate #(
    parameter int W_ADDR      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W_ADDR-1:0] req_addr,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_m_mode,
    output logic [W_ADDR-1:0] pmp_d_addr,
    output logic              pmp_d_m_mode,
    output logic              pmp_d_write,
    input  logic              pmp_d_kill,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [W_ADDR-1:0] bus_addr,
    output logic              bus_write,
    output logic [1:0]        bus_size,
    input  logic              bus_resp_valid,
    input  logic              bus_resp_err,
    output logic              resp_valid,
    output logic              resp_err,
    output logic              resp_pmp_fault,
    output logic              resp_align_fault,
    output logic              fault_valid,
    output logic [W_ADDR-1:0] fault_addr,
    output logic              fault_write,
    input  logic              fault_clr
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [W_ADDR-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;
    logic                m_mode_q, m_mode_d;
    logic                err_q, err_d;
    logic                pmp_q, pmp_d;
    logic                align_q, align_d;
    logic                fault_valid_q, fault_valid_d;
    logic [W_ADDR-1:0]   fault_addr_q, fault_addr_d;
    logic                fault_write_q, fault_write_d;
    logic                misaligned;
    logic                fault_hit;

    // Reserved size 3 is treated as a word access.
    assign misaligned = ((size_q == 2'd1) && addr_q[0]) ||
                        (size_q[1] && (addr_q[1:0] != 2'b00));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        m_mode_d  = m_mode_q;
        err_d     = err_q;
        pmp_d     = pmp_q;
        align_d   = align_q;
        fault_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    write_d  = req_write;
                    size_d   = req_size;
                    m_mode_d = req_m_mode;
                    err_d    = 1'b0;
                    pmp_d    = 1'b0;
                    align_d  = 1'b0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (CHECK_ALIGN && misaligned) begin
                    align_d   = 1'b1;
                    fault_hit = 1'b1;
                    state_d   = S_DONE;
                end else if (pmp_d_kill) begin
                    pmp_d     = 1'b1;
                    fault_hit = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus_resp_valid) begin
                    err_d   = bus_resp_err;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // First fault wins, but a capture coincident with a clear takes the new fault.
    always_comb begin
        fault_valid_d = fault_clr ? 1'b0 : fault_valid_q;
        fault_addr_d  = fault_addr_q;
        fault_write_d = fault_write_q;
        if (fault_hit && (!fault_valid_q || fault_clr)) begin
            fault_valid_d = 1'b1;
            fault_addr_d  = addr_q;
            fault_write_d = write_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            write_q       <= 1'b0;
            size_q        <= 2'd0;
            m_mode_q      <= 1'b0;
            err_q         <= 1'b0;
            pmp_q         <= 1'b0;
            align_q       <= 1'b0;
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
            fault_write_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            size_q        <= size_d;
            m_mode_q      <= m_mode_d;
            err_q         <= err_d;
            pmp_q         <= pmp_d;
            align_q       <= align_d;
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
            fault_write_q <= fault_write_d;
        end
    end

    assign req_ready        = (state_q == S_IDLE);
    assign pmp_d_addr       = addr_q;
    assign pmp_d_m_mode     = m_mode_q;
    assign pmp_d_write      = write_q;
    assign bus_valid        = (state_q == S_ISSUE);
    assign bus_addr         = addr_q;
    assign bus_write        = write_q;
    assign bus_size         = size_q;
    assign resp_valid       = (state_q == S_DONE);
    assign resp_err         = resp_valid && err_q;
    assign resp_pmp_fault   = resp_valid && pmp_q;
    assign resp_align_fault = resp_valid && align_q;
    assign fault_valid      = fault_valid_q;
    assign fault_addr       = fault_addr_q;
    assign fault_write      = fault_write_q;

endmodule

// File: tb/tb_hazard3_pmp_lsu_gate.sv
// Directed bench for hazard3_pmp_lsu_gate: expected responses are queued at
// request time and checked by a monitor when resp_valid pulses.
`timescale 1ns/1ps
module tb_hazard3_pmp_lsu_gate;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_m_mode = 1'b0;
    logic [31:0] pmp_d_addr;
    logic        pmp_d_m_mode;
    logic        pmp_d_write;
    logic        pmp_d_kill = 1'b0;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_addr;
    logic        bus_write;
    logic [1:0]  bus_size;
    logic        bus_resp_valid = 1'b0;
    logic        bus_resp_err = 1'b0;
    logic        resp_valid;
    logic        resp_err;
    logic        resp_pmp_fault;
    logic        resp_align_fault;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic        fault_write;
    logic        fault_clr = 1'b0;

    hazard3_pmp_lsu_gate #(.W_ADDR(32), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_m_mode(req_m_mode),
        .pmp_d_addr(pmp_d_addr), .pmp_d_m_mode(pmp_d_m_mode),
        .pmp_d_write(pmp_d_write), .pmp_d_kill(pmp_d_kill),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_write(bus_write), .bus_size(bus_size),
        .bus_resp_valid(bus_resp_valid), .bus_resp_err(bus_resp_err),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_pmp_fault(resp_pmp_fault), .resp_align_fault(resp_align_fault),
        .fault_valid(fault_valid), .fault_addr(fault_addr),
        .fault_write(fault_write), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic err;
        logic pmp;
        logic align;
        int   due;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_resp", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_err",   32'(resp_err),         32'(e.err));
                chk("resp_pmp",   32'(resp_pmp_fault),   32'(e.pmp));
                chk("resp_align", 32'(resp_align_fault), 32'(e.align));
                chk("resp_cycle", 32'(cyc),              32'(e.due));
            end
        end
    end

    // One request end to end; returns at the negedge of the DONE cycle.
    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [1:0] sz,
                          input logic kill, input int rdly, input int rspdly,
                          input logic berr, input logic clr,
                          input logic e_err, input logic e_pmp, input logic e_align);
        exp_t e;
        int   acc;
        logic to_bus;
        to_bus = !(e_pmp || e_align);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_size = sz;
        req_m_mode = 1'b0; pmp_d_kill = kill;
        acc = cyc;
        e.err = e_err; e.pmp = e_pmp; e.align = e_align;
        e.due = acc + (to_bus ? 4 + rdly + rspdly : 2);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        fault_clr = clr;
        chk("pmp_d_addr", pmp_d_addr, addr);
        chk("pmp_d_write", 32'(pmp_d_write), 32'(wr));
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (to_bus) begin
            @(negedge clk);
            for (int i = 0; i < rdly; i++) begin
                chk("bus_valid_hold", 32'(bus_valid), 32'd1);
                chk("bus_addr_hold", bus_addr, addr);
                chk("bus_size_hold", 32'(bus_size), 32'(sz));
                chk("req_ready_issue", 32'(req_ready), 32'd0);
                @(negedge clk);
            end
            chk("bus_valid", 32'(bus_valid), 32'd1);
            chk("bus_addr", bus_addr, addr);
            chk("bus_write", 32'(bus_write), 32'(wr));
            bus_ready = 1'b1;
            @(negedge clk);
            bus_ready = 1'b0;
            chk("bus_valid_drop", 32'(bus_valid), 32'd0);
            for (int i = 0; i < rspdly; i++) @(negedge clk);
            bus_resp_valid = 1'b1; bus_resp_err = berr;
            @(negedge clk);
            bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
        end else begin
            @(negedge clk);
            chk("no_bus_on_fault", 32'(bus_valid), 32'd0);
        end
        fault_clr = 1'b0;
    endtask

    task automatic clear_fault();
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("fault_cleared", 32'(fault_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t dropped;
        repeat (2) @(negedge clk);
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_fault_valid", 32'(fault_valid), 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
        chk("rst_pmp_d_addr", pmp_d_addr, 32'd0);
        rst_n = 1'b1;

        // 1: plain load through the bus, 4-cycle latency
        do_req(32'h2000_0004, 1'b0, 2'd2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_fault_valid", 32'(fault_valid), 32'd0);

        // 2: PMP-killed store
        do_req(32'h1000_0010, 1'b1, 2'd2, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_fault_valid", 32'(fault_valid), 32'd1);
        chk("t2_fault_addr", fault_addr, 32'h1000_0010);
        chk("t2_fault_write", 32'(fault_write), 32'd1);
        clear_fault();

        // 3: misaligned halfword, alignment beats PMP
        do_req(32'h0000_0003, 1'b0, 2'd1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_fault_addr", fault_addr, 32'h0000_0003);
        chk("t3_fault_write", 32'(fault_write), 32'd0);
        clear_fault();

        // 4: bus stall of 5 cycles then bus error; bus errors are not captured
        do_req(32'h4000_0008, 1'b0, 2'd2, 1'b0, 5, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_fault_valid", 32'(fault_valid), 32'd0);

        // 5: first fault wins; clear coincident with capture takes the new fault
        do_req(32'h0000_0100, 1'b0, 2'd2, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_req(32'h0000_0200, 1'b1, 2'd2, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_first_wins", fault_addr, 32'h0000_0100);
        chk("t5_first_write", 32'(fault_write), 32'd0);
        do_req(32'h0000_0300, 1'b1, 2'd2, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5_clr_capture_valid", 32'(fault_valid), 32'd1);
        chk("t5_clr_capture_addr", fault_addr, 32'h0000_0300);

        // alignment boundaries: odd byte is fine, reserved size 3 acts as word
        do_req(32'h0000_0005, 1'b0, 2'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_req(32'h0000_0006, 1'b0, 2'd3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("size3_no_recapture", fault_addr, 32'h0000_0300);

        // 6: reset while waiting for the bus response
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h3000_0000; req_write = 1'b0; req_size = 2'd2;
        pmp_d_kill = 1'b0;
        dropped.err = 1'b0; dropped.pmp = 1'b0; dropped.align = 1'b0; dropped.due = cyc + 4;
        sb.push_back(dropped);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("t6_bus_valid", 32'(bus_valid), 32'd1);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("t6_rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("t6_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("t6_rst_fault_valid", 32'(fault_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_resp_valid = 1'b1;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        @(negedge clk);
        chk("t6_no_stray_resp", 32'(resp_valid), 32'd0);
        do_req(32'h2000_0040, 1'b1, 2'd2, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
